// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control-decode types: opcode map, field encodings and the control bundle.
package riscv_ctrl_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_R      = 7'b0110011,
      OP_I      = 7'b0010011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } opcode_e;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   // reg_w / mem_w carry {funct3, enable} so EX/MEM see the access width.
   typedef struct packed {
      logic [1:0] alu_op;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       alu_a_pc;
      logic [1:0] result_src;
      logic [3:0] mem_w;
      logic       alu_src;
      logic [2:0] imm_src;
      logic [3:0] reg_w;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I main decoder: instruction -> control bundle plus illegal flag.
module ctrl_decode_comb
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   ctrl_t      raw;
   logic       bad;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   always_comb begin
      raw = '0;
      bad = 1'b0;
      case (opcode)
         OP_LOAD: begin
            raw.reg_w      = {funct3, 1'b1};
            raw.imm_src    = IMM_I;
            raw.alu_src    = 1'b1;
            raw.result_src = RES_MEM;
            raw.alu_op     = ALU_ADD;
            bad            = (funct3 == 3'd3) || (funct3 >= 3'd6);
         end
         OP_STORE: begin
            raw.mem_w   = {funct3, 1'b1};
            raw.imm_src = IMM_S;
            raw.alu_src = 1'b1;
            raw.alu_op  = ALU_ADD;
            bad         = funct3 > 3'd2;
         end
         OP_R: begin
            raw.reg_w  = {funct3, 1'b1};
            raw.alu_op = ALU_FN;
            // Only base ADD/SUB and SRL/SRA admit the alternate funct7.
            bad = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
         end
         OP_I: begin
            raw.reg_w   = {funct3, 1'b1};
            raw.imm_src = IMM_I;
            raw.alu_src = 1'b1;
            raw.alu_op  = ALU_FN;
         end
         OP_BRANCH: begin
            raw.branch  = 1'b1;
            raw.imm_src = IMM_B;
            raw.alu_op  = ALU_BR;
            bad         = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         OP_JAL: begin
            raw.reg_w      = {funct3, 1'b1};
            raw.jump       = 1'b1;
            raw.imm_src    = IMM_J;
            raw.result_src = RES_PC4;
         end
         OP_JALR: begin
            raw.reg_w      = {funct3, 1'b1};
            raw.jump       = 1'b1;
            raw.jalr       = 1'b1;
            raw.imm_src    = IMM_I;
            raw.alu_src    = 1'b1;
            raw.result_src = RES_PC4;
            raw.alu_op     = ALU_ADD;
            bad            = funct3 != 3'd0;
         end
         OP_LUI: begin
            raw.reg_w      = {funct3, 1'b1};
            raw.imm_src    = IMM_U;
            raw.result_src = RES_IMM;
         end
         OP_AUIPC: begin
            raw.reg_w    = {funct3, 1'b1};
            raw.imm_src  = IMM_U;
            raw.alu_a_pc = 1'b1;
            raw.alu_src  = 1'b1;
            raw.alu_op   = ALU_ADD;
         end
         default: bad = 1'b1;
      endcase
   end

   assign illegal = bad;
   assign ctrl    = bad ? ctrl_t'('0) : raw;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered, handshaked ID stage: decoder feeding a 2-entry skid buffer, with flush and illegal count.
module ctrl_decode_stage
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int SKID_EN   = 1,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output ctrl_t                out_ctrl,
   output logic [31:0]          out_instr,
   output logic [XLEN-1:0]      out_pc,
   output logic                 out_illegal,
   output logic [ILL_CNT_W-1:0] ill_count
);

   typedef struct packed {
      ctrl_t            ctrl;
      logic [31:0]      instr;
      logic [XLEN-1:0]  pc;
      logic             ill;
   } entry_t;

   ctrl_t  dec_ctrl;
   logic   dec_ill;
   entry_t in_ent, main_q, skid_q;
   logic   main_v, skid_v;
   logic   accept, pop;

   ctrl_decode_comb u_dec (
      .instr   (in_instr),
      .ctrl    (dec_ctrl),
      .illegal (dec_ill)
   );

   assign in_ent = '{ctrl: dec_ctrl, instr: in_instr, pc: in_pc, ill: dec_ill};

   // Skid mode keeps in_ready purely registered; single-register mode trades that for no skid.
   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = !skid_v;
      end else begin : g_single
         assign in_ready = !main_v || out_ready;
      end
   endgenerate

   assign accept = in_valid && in_ready;
   assign pop    = main_v && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (pop) begin
         if (skid_v) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
         end else begin
            main_v <= accept;
            if (accept) main_q <= in_ent;
         end
      end else if (!main_v) begin
         main_v <= accept;
         if (accept) main_q <= in_ent;
      end else if (accept) begin
         skid_q <= in_ent;
         skid_v <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_count <= '0;
      end else if (!flush && accept && dec_ill && (ill_count != {ILL_CNT_W{1'b1}})) begin
         ill_count <= ill_count + 1'b1;
      end
   end

   assign out_valid   = main_v;
   assign out_ctrl    = main_q.ctrl;
   assign out_instr   = main_q.instr;
   assign out_pc      = main_q.pc;
   assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: FIFO-queue reference model checked every cycle plus literal pins.
module tb_ctrl_decode_stage;
   import riscv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_illegal;
   ctrl_t       out_ctrl;
   logic [31:0] out_instr, out_pc;
   logic [7:0]  ill_count;
   logic        in_ready2, out_valid2, out_illegal2;
   ctrl_t       out_ctrl2;
   logic [31:0] out_instr2, out_pc2;
   logic [1:0]  ill_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_ctrl(out_ctrl), .out_instr(out_instr),
      .out_pc(out_pc), .out_illegal(out_illegal), .ill_count(ill_count));

   ctrl_decode_stage #(.ILL_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
      .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_instr(out_instr2),
      .out_pc(out_pc2), .out_illegal(out_illegal2), .ill_count(ill_count2));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Reference decode written straight from the opcode table.
   typedef struct {
      ctrl_t       c;
      logic        ill;
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = i[14:12];
      f7 = i[31:25];
      e.c = '0;
      e.ill = 1'b0;
      e.instr = i;
      e.pc = pc;
      case (i[6:0])
         7'h03: begin e.c.reg_w = {f3, 1'b1}; e.c.alu_src = 1; e.c.result_src = 2'b01;
                      e.ill = (f3 == 3) || (f3 >= 6); end
         7'h23: begin e.c.mem_w = {f3, 1'b1}; e.c.imm_src = 3'b001; e.c.alu_src = 1;
                      e.ill = f3 > 2; end
         7'h33: begin e.c.reg_w = {f3, 1'b1}; e.c.alu_op = 2'b10;
                      e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
         7'h13: begin e.c.reg_w = {f3, 1'b1}; e.c.alu_src = 1; e.c.alu_op = 2'b10; end
         7'h63: begin e.c.branch = 1; e.c.imm_src = 3'b010; e.c.alu_op = 2'b01;
                      e.ill = (f3 == 2) || (f3 == 3); end
         7'h6F: begin e.c.reg_w = {f3, 1'b1}; e.c.jump = 1; e.c.imm_src = 3'b011;
                      e.c.result_src = 2'b10; end
         7'h67: begin e.c.reg_w = {f3, 1'b1}; e.c.jump = 1; e.c.jalr = 1; e.c.alu_src = 1;
                      e.c.result_src = 2'b10; e.ill = f3 != 0; end
         7'h37: begin e.c.reg_w = {f3, 1'b1}; e.c.imm_src = 3'b100; e.c.result_src = 2'b11; end
         7'h17: begin e.c.reg_w = {f3, 1'b1}; e.c.imm_src = 3'b100; e.c.alu_a_pc = 1;
                      e.c.alu_src = 1; end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) e.c = '0;
      return e;
   endfunction

   // Model: the stage is a 2-deep FIFO of decoded words.
   exp_t q[$];
   int   mcnt, mcnt2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt = 0;
         mcnt2 = 0;
      end else begin
         automatic bit acc = in_valid && (q.size() < 2);
         automatic bit pp  = (q.size() > 0) && out_ready;
         automatic exp_t e = model_decode(in_instr, in_pc);
         if (flush) begin
            q.delete();
         end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
               q.push_back(e);
               if (e.ill) begin
                  if (mcnt < 255) mcnt++;
                  if (mcnt2 < 3) mcnt2++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("ill_count", 32'(ill_count), 32'(mcnt));
      chk("ill_count_w2", 32'(ill_count2), 32'(mcnt2));
      if (q.size() > 0) begin
         chk("out_ctrl", 32'(out_ctrl), 32'(q[0].c));
         chk("out_instr", out_instr, q[0].instr);
         chk("out_pc", out_pc, q[0].pc);
         chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic put(input logic [31:0] i, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = i;
      in_pc = pc;
   endtask

   logic [31:0] pool [0:11];

   initial begin
      pool[0] = 32'h00412083; pool[1] = 32'h0020A023; pool[2] = 32'h002081B3;
      pool[3] = 32'h00108093; pool[4] = 32'h00208463; pool[5] = 32'h008000EF;
      pool[6] = 32'h000280E7; pool[7] = 32'h000012B7; pool[8] = 32'h00001297;
      pool[9] = 32'hFFFFFFFF; pool[10] = 32'h402091B3; pool[11] = 32'h0000A063;

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      chk("rst_ill_count", 32'(ill_count), 32'd0);
      rst_n = 1'b1;
      step();

      // LW x1,4(x2)
      put(32'h00412083, 32'h100);
      step();
      in_valid = 1'b0;
      chk("lw_valid", 32'(out_valid), 32'd1);
      chk("lw_reg_w", 32'(out_ctrl.reg_w), 32'b0101);
      chk("lw_result_src", 32'(out_ctrl.result_src), 32'b01);
      chk("lw_imm_src", 32'(out_ctrl.imm_src), 32'b000);
      chk("lw_pc", out_pc, 32'h100);
      step();
      chk("lw_drained", 32'(out_valid), 32'd0);

      // Backpressure: two captured, third stalls, order kept on release.
      out_ready = 1'b0;
      put(32'h002081B3, 32'h200); step();
      put(32'h00108093, 32'h204); step();
      put(32'h00208463, 32'h208);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_head_a", out_instr, 32'h002081B3);
      step();
      out_ready = 1'b1;
      step();
      chk("bp_head_b", out_instr, 32'h00108093);
      step();
      chk("bp_head_c", out_instr, 32'h00208463);
      in_valid = 1'b0;
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush with both entries full and an illegal word presented.
      out_ready = 1'b0;
      put(32'h00412083, 32'h300); step();
      put(32'h0020A023, 32'h304); step();
      put(32'hFFFFFFFF, 32'h308);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_ill_count", 32'(ill_count), 32'd0);

      // Illegal words.
      out_ready = 1'b1;
      put(32'hFFFFFFFF, 32'h400); step();
      chk("ill_ff_flag", 32'(out_illegal), 32'd1);
      chk("ill_ff_ctrl", 32'(out_ctrl), 32'd0);
      put(32'h0020B023, 32'h404); step();
      chk("ill_sw_flag", 32'(out_illegal), 32'd1);
      chk("ill_sw_ctrl", 32'(out_ctrl), 32'd0);
      chk("ill_count_2", 32'(ill_count), 32'd2);
      put(32'h00000000, 32'h408); step();
      put(32'h0041B083, 32'h40C); step();
      put(32'h000290E7, 32'h410); step();
      put(32'h022081B3, 32'h414); step();
      put(32'h402091B3, 32'h418); step();
      in_valid = 1'b0;
      chk("ill_count_7", 32'(ill_count), 32'd7);
      chk("ill_count_sat", 32'(ill_count2), 32'd3);
      step();

      // JALR, AUIPC, LUI, JAL.
      put(32'h000280E7, 32'h500); step();
      chk("jalr_jalr", 32'(out_ctrl.jalr), 32'd1);
      chk("jalr_result", 32'(out_ctrl.result_src), 32'b10);
      chk("jalr_legal", 32'(out_illegal), 32'd0);
      put(32'h00001297, 32'h504); step();
      chk("auipc_a_pc", 32'(out_ctrl.alu_a_pc), 32'd1);
      chk("auipc_imm", 32'(out_ctrl.imm_src), 32'b100);
      put(32'h000012B7, 32'h508); step();
      chk("lui_result", 32'(out_ctrl.result_src), 32'b11);
      put(32'h008000EF, 32'h50C); step();
      chk("jal_imm", 32'(out_ctrl.imm_src), 32'b011);
      in_valid = 1'b0;
      step();

      // Mixed traffic with random backpressure and occasional flush.
      for (int n = 0; n < 300; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_instr = pool[$urandom_range(0, 11)];
         in_pc = 32'h1000 + 32'(n) * 4;
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 29) == 0);
         step();
      end
      flush = 1'b0;

      // Reset in the middle of traffic.
      out_ready = 1'b0;
      put(32'hFFFFFFFF, 32'h600); step();
      put(32'h00412083, 32'h604); step();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_ill_count", 32'(ill_count), 32'd0);
      step();
      in_valid = 1'b0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
